// File: rtl/hex_keypad_entry_pkg.sv
// Shared definitions for the hex keypad entry block: FSM state encoding,
// key-code width and the row priority encoder.
package hex_keypad_entry_pkg;

  localparam int KEY_W = 4;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Index of the lowest-numbered active-low row; 3 when only row 3 is low.
  function automatic logic [1:0] low_row_idx(input logic [3:0] rows_n);
    if (!rows_n[0])      return 2'd0;
    else if (!rows_n[1]) return 2'd1;
    else if (!rows_n[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/hex_keypad_entry_sync.sv
// Two-flop synchronizer, width-parameterized, synchronous active-high reset
// to a configurable idle value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops to settle metastability from the async input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hex_keypad_entry.sv
// Hex keypad scanner with press/release debounce and a 4-nibble entry shift
// register. Optional autorepeat while a key is held is enabled by defining
// KEYPAD_AUTOREPEAT_EN; without it each press yields exactly one key_valid.
module hex_keypad_entry
  import hex_keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rows_n,
  output logic [3:0]       cols_n,
  input  logic             clear,
  output logic [15:0]      value,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);

  // Reject configurations the scan/debounce timing cannot support.
  if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("hex_keypad_entry: invalid timing parameters");
  end

  logic [3:0]        w_rows_s;
  logic [1:0]        r_state;
  logic [1:0]        r_col;
  logic [1:0]        r_row;
  logic [3:0]        r_pattern;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [DB_W-1:0]   r_cnt;
  logic [15:0]       r_value;
  logic [KEY_W-1:0]  r_key_code;
  logic              r_key_valid;
  logic              w_accept;
  logic              w_rpt_fire;
  logic [KEY_W-1:0]  w_code;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rows_n),
    .o_q (w_rows_s)
  );

  assign w_code = {r_row, r_col};
  assign cols_n = ~(4'b0001 << r_col);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first;

  // First repeat waits the long delay, later ones the shorter period.
  assign w_rpt_fire = (r_state == ST_HELD) && (w_rows_s != 4'hF) &&
                      (r_rpt_cnt == (r_rpt_first ? RPT_W'(REPEAT_DELAY - 1)
                                                 : RPT_W'(REPEAT_PERIOD - 1)));

  // Repeat timer runs only while HELD and restarts after every repeat.
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_HELD) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_rpt_fire) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b0;
    end else if (r_rpt_cnt != RPT_W'(RPT_MAX)) begin
      r_rpt_cnt <= r_rpt_cnt + 1'b1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  // A key is accepted on the last stable debounce cycle, or on a repeat tick.
  assign w_accept = ((r_state == ST_DEBOUNCE) && (w_rows_s == r_pattern) && (r_cnt == DB_LAST))
                    || w_rpt_fire;

  // Scan / debounce / held / release state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_SCAN;
      r_col      <= 2'd0;
      r_row      <= 2'd0;
      r_pattern  <= 4'hF;
      r_scan_cnt <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          // Rows settle through the synchronizer, so only the last dwell cycle is trusted.
          if (r_scan_cnt == SCAN_LAST) begin
            if (w_rows_s != 4'hF) begin
              r_state   <= ST_DEBOUNCE;
              r_pattern <= w_rows_s;
              r_row     <= low_row_idx(w_rows_s);
              r_cnt     <= '0;
            end else begin
              r_col      <= r_col + 2'd1;
              r_scan_cnt <= '0;
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_rows_s != r_pattern) begin
            r_state    <= ST_SCAN;
            r_col      <= r_col + 2'd1;
            r_scan_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= ST_HELD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (w_rows_s == 4'hF) begin
            r_state <= ST_RELEASE;
            r_cnt   <= '0;
          end
        end
        default: begin // ST_RELEASE
          if (w_rows_s != 4'hF) begin
            r_state <= ST_HELD;
          end else if (r_cnt == DB_LAST) begin
            r_state    <= ST_SCAN;
            r_col      <= r_col + 2'd1;
            r_scan_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Output pulse, last key code and the entry shift register with clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_value     <= '0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= w_code;
        r_value    <= clear ? {12'h000, w_code} : {r_value[11:0], w_code};
      end else if (clear) begin
        r_value <= '0;
      end
    end
  end

  assign value     = r_value;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a keypad matrix model.
module tb_hex_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  localparam int RDLY     = 40;
  localparam int RPER     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_valid;

  logic [15:0] pressed;
  logic [3:0]  glitch;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int npulse   = 0;

  hex_keypad_entry #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk), .rst(rst), .rows_n(rows_n), .cols_n(cols_n), .clear(clear),
    .value(value), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
    rows_n = rows_n & ~glitch;
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (key_valid) npulse++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int bound, output int lat);
    int start;
    start = npulse;
    lat   = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (npulse != start) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic wait_cols(input logic [3:0] prev, input logic [3:0] target, output bit ok);
    logic [3:0] last;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      last = cols_n;
      tick();
      if (last == prev && cols_n == target) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic press_key(input logic [3:0] code, input string tag);
    int lat;
    pressed[code] = 1'b1;
    wait_pulse(40, lat);
    chk({tag, "_seen"}, 32'(lat > 0), 32'd1);
    chk({tag, "_code"}, 32'(key_code), 32'(code));
    repeat (20) tick();
    pressed = '0;
    repeat (20) tick();
  endtask

  initial begin
    int         lat;
    int         p0;
    int         t0;
    bit         ok;
    int         offs[$];
    int         exp_offs[$];
    int         exp_extra;
    logic [15:0] exp_v9;

`ifdef KEYPAD_AUTOREPEAT_EN
    exp_offs  = '{40, 56, 72, 88};
    exp_extra = 4;
    exp_v9    = 16'h9999;
`else
    exp_extra = 0;
    exp_v9    = 16'h0009;
`endif

    rst = 1'b1; clear = 1'b0; pressed = '0; glitch = '0;
    repeat (3) tick();
    chk("rst_cols",  32'(cols_n),    32'hE);
    chk("rst_value", 32'(value),     32'h0);
    chk("rst_code",  32'(key_code),  32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Key 9 (row 2, column 1), held 100 cycles past acceptance.
    pressed[9] = 1'b1;
    wait_pulse(40, lat);
    chk("k9_seen",    32'(lat > 0),   32'd1);
    chk("k9_latency", 32'(lat <= 27), 32'd1);
    chk("k9_code",    32'(key_code),  32'h9);
    chk("k9_value1",  32'(value),     32'h9);
    p0 = npulse;
    repeat (100) tick();
    chk("k9_hold_pulses", 32'(npulse - p0), 32'(exp_extra));
    pressed = '0;
    repeat (20) tick();
    chk("k9_value", 32'(value), 32'(exp_v9));

    // Sequence 1,2,3,A,B then clear.
    press_key(4'h1, "seq1");
    press_key(4'h2, "seq2");
    press_key(4'h3, "seq3");
    press_key(4'hA, "seqA");
    press_key(4'hB, "seqB");
    chk("seq_value", 32'(value), 32'h23AB);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_value", 32'(value), 32'h0);

    // 5-cycle glitch on row 0 at the start of column 0.
    wait_cols(4'b0111, 4'b1110, ok);
    chk("glitch_align", 32'(ok), 32'd1);
    p0 = npulse;
    glitch = 4'b0001;
    repeat (5) tick();
    chk("glitch_frozen", 32'(cols_n), 32'hE);
    glitch = 4'b0000;
    repeat (3) tick();
    chk("glitch_resume", 32'(cols_n), 32'hD);
    repeat (30) tick();
    chk("glitch_no_pulse", 32'(npulse - p0), 32'd0);

    // Hold 5, press F as well: no rollover.
    pressed[5] = 1'b1;
    wait_pulse(40, lat);
    chk("k5_seen", 32'(lat > 0),  32'd1);
    chk("k5_code", 32'(key_code), 32'h5);
    repeat (5) tick();
    pressed[15] = 1'b1;
    p0 = npulse;
    repeat (25) tick();
    chk("k5_blocks_F", 32'(npulse - p0), 32'd0);
    pressed = '0;
    repeat (30) tick();
    chk("k5F_release_quiet", 32'(npulse - p0), 32'd0);
    press_key(4'hF, "kF");
    chk("kF_value", 32'(value), 32'h005F);

    // Key 7 with clear in the accepting cycle.
    wait_cols(4'b1011, 4'b0111, ok);
    chk("k7_align", 32'(ok), 32'd1);
    pressed[7] = 1'b1;
    repeat (11) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("k7_valid", 32'(key_valid), 32'd1);
    chk("k7_code",  32'(key_code),  32'h7);
    chk("k7_value", 32'(value),     32'h0007);

    // Reset while HELD, key re-detected afterwards.
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("hrst_cols",  32'(cols_n),    32'hE);
    chk("hrst_value", 32'(value),     32'h0);
    chk("hrst_code",  32'(key_code),  32'h0);
    chk("hrst_valid", 32'(key_valid), 32'h0);
    rst = 1'b0;
    wait_pulse(40, lat);
    chk("k7_redetect", 32'(lat > 0),  32'd1);
    chk("k7_re_code",  32'(key_code), 32'h7);
    chk("k7_re_value", 32'(value),    32'h0007);
    pressed = '0;
    repeat (20) tick();

    // Key 4 held 100 cycles: autorepeat timing.
    pressed[4] = 1'b1;
    wait_pulse(40, lat);
    chk("k4_seen", 32'(lat > 0),  32'd1);
    chk("k4_code", 32'(key_code), 32'h4);
    t0 = cyc;
    repeat (100) begin
      tick();
      if (key_valid) offs.push_back(cyc - t0);
    end
    chk("k4_repeat_count", 32'(offs.size()), 32'(exp_offs.size()));
    foreach (exp_offs[i])
      chk($sformatf("k4_repeat_off%0d", i),
          32'((i < offs.size()) ? offs[i] : -1), 32'(exp_offs[i]));
    pressed = '0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_keypad_entry.md
HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each keypad column is driven; SHALL be >= 4.
REQ-002 Parameter DEBOUNCE, default 50000: cycles of stable input required to accept a press or a release.
REQ-003 Parameter REPEAT_DELAY, default 25000000; REPEAT_PERIOD, default 5000000: autorepeat timing, used only under REQ-024.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rows_n  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-007 cols_n  output  4  keypad column drive, one-hot active-low.
REQ-008 clear  input  1  synchronous clear of the entered word.
REQ-009 value  output  16  entered hex word, newest nibble in [3:0]; feeds the 4-digit display decoder directly.
REQ-010 key_code  output  4  code of the most recently accepted key.
REQ-011 key_valid  output  1  one-cycle pulse per accepted key.

Function
REQ-012 rows_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized rows_s.
REQ-013 Key code SHALL be {row index[1:0], column index[1:0]}, with index 0 = bit 0.
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: drive column c low for SCAN_DIV cycles, then advance c to (c+1) mod 4; rows_s is sampled only on the last dwell cycle.
REQ-016 SCAN -> DEBOUNCE if the sampled rows_s != 4'hF; latch the pattern and the lowest-index low row; the column stays frozen.
REQ-017 DEBOUNCE: count cycles while rows_s equals the latched pattern; any change -> SCAN, resuming at column c+1.
REQ-018 DEBOUNCE -> HELD when the count reaches DEBOUNCE; in that same cycle key_valid=1, key_code=code, value <= {value[11:0], code}.
REQ-019 HELD: the column stays frozen and no further key is accepted; rows_s == 4'hF -> RELEASE.
REQ-020 RELEASE: count cycles with rows_s == 4'hF; any low row -> HELD; count reaching DEBOUNCE -> SCAN at column c+1.
REQ-021 Press-to-pulse latency SHALL be at most 2 + 4*SCAN_DIV + DEBOUNCE + 1 cycles.
REQ-022 Keys other than the first latched key SHALL be ignored until all keys are released (no rollover).
REQ-023 clear=1: value <= 0; if key_valid occurs in the same cycle, value <= {12'h000, code}; clear SHALL NOT affect the FSM.

Configuration
REQ-024 Macro KEYPAD_AUTOREPEAT_EN defined: in HELD, after REPEAT_DELAY cycles, re-emit the held key as in REQ-018, then again every REPEAT_PERIOD cycles until leaving HELD.
REQ-025 Macro KEYPAD_AUTOREPEAT_EN undefined: the repeat counter is absent and exactly one key_valid is produced per press.

Reset
REQ-026 rst SHALL force state=SCAN, c=0, cols_n=4'b1110, value=16'h0000, key_code=4'h0, key_valid=0, all counters 0, synchronizer flops 4'hF.
REQ-027 rst asserted mid-DEBOUNCE, HELD or RELEASE SHALL abort that state with no key_valid pulse; a key still held after reset is re-detected from SCAN.
REQ-028 rst SHALL take priority over clear and key acceptance.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the key-code width constant.
REQ-030 The synchronizer SHALL be a sub-module, sync_2ff, parameterized by width.
REQ-031 Counters SHALL be sized with $clog2 of the largest parameter they count to and SHALL saturate, never wrap.

Verification (SCAN_DIV=4, DEBOUNCE=8, REPEAT_DELAY=40, REPEAT_PERIOD=16)
REQ-032 Press row 2/column 1 (code 4'h9), hold 100 cycles, release -> one key_valid, key_code=9, value=16'h0009.
REQ-033 Keys 1,2,3,A,B in sequence -> value=16'h23AB after the fifth pulse; clear -> 16'h0000 next cycle.
REQ-034 Glitch of 5 cycles on row 0 -> no key_valid; scan resumes at the next column.
REQ-035 Hold key 5 while pressing key F -> single pulse with code 5; F is accepted only after full release and a new press.
REQ-036 clear coincident with the key 7 pulse -> value=16'h0007; rst asserted in HELD -> all outputs at reset values next cycle.
REQ-037 With KEYPAD_AUTOREPEAT_EN, hold key 4 for 100 cycles after acceptance -> pulses at +0, +40, +56, +72, +88 relative to the first; without the macro, one pulse only.
